leaf_stream_packetizer: RTL and testbench
=========================================

Name: leaf_stream_packetizer

Overview:
- Transmit end of the leaf user-stream protocol: accepts 32-bit words from an HLS operator output port (ap_vld/ap_ack handshake) and emits 49-bit BFT data packets.
- Sends only while it holds credits for the remote leaf's receive BRAM; freespace-update packets arriving from the BFT replenish those credits.
- Sits between an operator's Output_x_V_V port and the BFT leaf attachment, one instance per output stream.

Parameters:
- PACKET_BITS, 49, BFT packet width (fixed layout below).
- PAYLOAD_BITS, 32, user word width.
- NUM_BRAM_ADDR_BITS, 7, remote receive buffer address width; buffer depth = 2^7 = 128 words.
- FREESPACE_UPDATE_SIZE, 64, credits granted per freespace-update packet.
- SRC_LEAF, 0, 3-bit leaf id of this block; credit packets are accepted only when addressed to it.
- DEST_LEAF, 1, 3-bit destination leaf id.
- DEST_PORT, 2, 4-bit destination port id.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- din_user2tx  in  32  payload word from the operator.
- vld_user2tx  in  1  payload valid.
- ack_tx2user  out  1  word accepted; a transfer occurs when vld_user2tx && ack_tx2user in the same cycle.
- dout_tx2bft  out  49  packet to the BFT; bit 48 is the packet-valid bit.
- din_bft2tx  in  49  packet from the BFT; carries credit returns.
- credit_overflow  out  1  sticky error flag.

Behaviour:
- Packet layout, both directions:
  - [48] valid
  - [47:45] leaf
  - [44:41] port
  - [40:34] addr
  - [33:32] type: 00 data, 01 freespace update, 10/11 reserved
  - [31:0] payload
- Outgoing data packet: {1, DEST_LEAF, DEST_PORT, wr_addr, 2'b00, word}.
- Incoming credit packet is recognised when [48]=1, [47:45]=SRC_LEAF, [33:32]=01. Payload and addr are ignored. Any other incoming packet is ignored.
- Registers:
  - credits, 8 bits, range 0..128.
  - wr_addr, 7 bits.
  - state.
  - dout register.
  - credit_overflow.
- Reset (reset==0 at a clock edge):
  - credits=128, wr_addr=0, state=RUN.
  - dout_tx2bft=0, ack_tx2user=0, credit_overflow=0.
  - Reset asserted mid-stream drops any packet in the dout register. No partial packet is emitted afterwards.
- States:
  - RUN: credits>0. ack_tx2user=1.
  - BLOCKED: credits==0. ack_tx2user=0.
  - ack_tx2user is a registered function of state only; it never depends on vld_user2tx.
- Transfer in cycle N:
  - dout_tx2bft holds the data packet in cycle N+1 (latency 1).
  - wr_addr increments modulo 128 (127 wraps to 0).
  - credits decrements by 1.
  - One packet per cycle maximum; back-to-back transfers give back-to-back packets.
- No transfer in cycle N: dout_tx2bft[48]=0 in cycle N+1 (whole bus driven 0).
- Credit update computed every cycle: next = credits − (transfer?1:0) + (credit_pkt?FREESPACE_UPDATE_SIZE:0).
  - Computed in 9 bits.
  - If next>128: credits saturate to 128 and credit_overflow sets, sticky until reset.
  - Simultaneous transfer and credit packet: both apply in the same cycle.
- State transitions:
  - RUN→BLOCKED when next credits==0.
  - BLOCKED→RUN when next credits>0.
  - The ack change is visible the cycle after the credit change, so a transfer is never accepted at credits==0.
- vld_user2tx held high with ack low: the word is not consumed; the operator holds it (ap_vld/ap_ack semantics).

Test Plan:
- Reset, then vld high with words 0x100..0x104 for 5 cycles -> five consecutive packets. Addrs 0..4, type 00, leaf DEST_LEAF, port DEST_PORT, payloads match. credits=123.
- Stream 128 words with no credit return -> ack drops after the 128th transfer. 129th word held, no packet with valid=1. State BLOCKED.
- While BLOCKED, inject one credit packet (leaf=SRC_LEAF, type 01) -> credits=64, ack=1 next cycle. 64 further words are sent with addrs 0..63 (wrap after 127).
- Credit packet in the same cycle as a transfer at credits=10 -> credits=73. No overflow.
- Credit packet at credits=100 -> credits saturate to 128, credit_overflow=1 and remains 1. A credit packet with wrong leaf or type 00 -> no change.
- Reset pulled low mid-stream at wr_addr=37 -> next cycle dout=0, ack=0. After release: credits=128, first packet addr 0, credit_overflow=0.

Source files
------------

// File: rtl/leaf_stream_packetizer.sv
// Leaf user-stream transmitter: wraps operator words into BFT data packets.
// Credit-based flow control against the remote leaf's receive buffer.
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SRC_LEAF              = 0,
  parameter int DEST_LEAF             = 1,
  parameter int DEST_PORT             = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_user2tx,
  input  logic                    vld_user2tx,
  output logic                    ack_tx2user,
  output logic [PACKET_BITS-1:0]  dout_tx2bft,
  input  logic [PACKET_BITS-1:0]  din_bft2tx,
  output logic                    credit_overflow
);

  localparam int AW = NUM_BRAM_ADDR_BITS;
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;
  localparam logic [CW-1:0] DEPTH = CW'(1 << AW);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] BLOCKED = 1'b1;

  logic [CW-1:0] credits;
  logic [AW-1:0] wr_addr;
  logic [0:0]    state;

  logic          xfer;
  logic          credit_pkt;
  logic [SW-1:0] cred_sum;
  logic [CW-1:0] cred_next;
  logic          cred_ovf;
  logic [0:0]    state_next;
  logic          unused_bft;

  assign unused_bft = ^{din_bft2tx[44:34], din_bft2tx[31:0]};

  assign xfer = vld_user2tx && ack_tx2user && (state == RUN);

  assign credit_pkt = din_bft2tx[48]
                   && (din_bft2tx[47:45] == 3'(SRC_LEAF))
                   && (din_bft2tx[33:32] == 2'b01);

  // Sum carries one extra bit so an over-grant is visible before saturation
  always_comb begin
    cred_sum = {1'b0, credits} - SW'(xfer);
    if (credit_pkt)
      cred_sum = cred_sum + SW'(FREESPACE_UPDATE_SIZE);
    cred_ovf  = cred_sum > SW'(DEPTH);
    cred_next = cred_ovf ? DEPTH : cred_sum[CW-1:0];
    state_next = (cred_next == '0) ? BLOCKED : RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      credits         <= DEPTH;
      wr_addr         <= '0;
      state           <= RUN;
      ack_tx2user     <= 1'b0;
      dout_tx2bft     <= '0;
      credit_overflow <= 1'b0;
    end else begin
      credits     <= cred_next;
      wr_addr     <= wr_addr + AW'(xfer);
      state       <= state_next;
      ack_tx2user <= (state_next == RUN);
      if (xfer)
        dout_tx2bft <= {1'b1, 3'(DEST_LEAF), 4'(DEST_PORT),
                        wr_addr, 2'b00, din_user2tx};
      else
        dout_tx2bft <= '0;
      if (cred_ovf)
        credit_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Directed self-checking bench for leaf_stream_packetizer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_leaf_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_user2tx;
  logic        vld_user2tx;
  logic        ack_tx2user;
  logic [48:0] dout_tx2bft;
  logic [48:0] din_bft2tx;
  logic        credit_overflow;

  int checks = 0;
  int errors = 0;

  leaf_stream_packetizer dut (
    .clk            (clk),
    .reset          (reset),
    .din_user2tx    (din_user2tx),
    .vld_user2tx    (vld_user2tx),
    .ack_tx2user    (ack_tx2user),
    .dout_tx2bft    (dout_tx2bft),
    .din_bft2tx     (din_bft2tx),
    .credit_overflow(credit_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] pkt(input logic [6:0] a,
                                      input logic [31:0] w);
    return {1'b1, 3'd1, 4'd2, a, 2'b00, w};
  endfunction

  function automatic logic [48:0] bft(input logic [2:0] leaf,
                                      input logic [1:0] typ);
    return {1'b1, leaf, 4'd5, 7'd9, typ, 32'hCAFE_0000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] a, input logic [31:0] w,
                      input string tag);
    din_user2tx = w;
    vld_user2tx = 1'b1;
    step();
    chk(tag, 64'(dout_tx2bft), 64'(pkt(a, w)));
  endtask

  initial begin
    reset       = 1'b0;
    din_user2tx = '0;
    vld_user2tx = 1'b0;
    din_bft2tx  = '0;
    step();
    step();
    chk("rst_dout", 64'(dout_tx2bft), 64'd0);
    chk("rst_ack", 64'(ack_tx2user), 64'd0);
    chk("rst_ovf", 64'(credit_overflow), 64'd0);
    chk("rst_credits", 64'(dut.credits), 64'd128);

    reset = 1'b1;
    step();
    chk("ack_after_rst", 64'(ack_tx2user), 64'd1);

    for (int i = 0; i < 5; i++)
      send(7'(i), 32'h100 + 32'(i), "burst5_pkt");
    vld_user2tx = 1'b0;
    step();
    chk("burst5_credits", 64'(dut.credits), 64'd123);
    chk("idle_dout", 64'(dout_tx2bft), 64'd0);

    for (int i = 5; i < 128; i++)
      send(7'(i), 32'hA000 + 32'(i), "fill_pkt");
    chk("fill_ack_low", 64'(ack_tx2user), 64'd0);
    chk("fill_credits", 64'(dut.credits), 64'd0);
    chk("fill_state", 64'(dut.state), 64'd1);

    din_user2tx = 32'hDEAD;
    step();
    chk("held_valid", 64'(dout_tx2bft[48]), 64'd0);
    chk("held_ack", 64'(ack_tx2user), 64'd0);
    step();
    chk("held_credits", 64'(dut.credits), 64'd0);

    din_bft2tx = bft(3'd0, 2'b01);
    step();
    din_bft2tx = '0;
    chk("grant_credits", 64'(dut.credits), 64'd64);
    chk("grant_ack", 64'(ack_tx2user), 64'd1);
    chk("grant_no_xfer", 64'(dout_tx2bft), 64'd0);

    for (int i = 0; i < 64; i++)
      send(7'(i), 32'h200 + 32'(i), "wrap_pkt");
    chk("wrap_ack_low", 64'(ack_tx2user), 64'd0);

    din_bft2tx = bft(3'd0, 2'b01);
    vld_user2tx = 1'b0;
    step();
    din_bft2tx = '0;
    for (int i = 64; i < 118; i++)
      send(7'(i), 32'h300 + 32'(i), "drain_pkt");
    vld_user2tx = 1'b0;
    step();
    chk("ten_credits", 64'(dut.credits), 64'd10);

    din_user2tx = 32'h5A5A;
    vld_user2tx = 1'b1;
    din_bft2tx  = bft(3'd0, 2'b01);
    step();
    din_bft2tx  = '0;
    vld_user2tx = 1'b0;
    chk("both_credits", 64'(dut.credits), 64'd73);
    chk("both_pkt", 64'(dout_tx2bft), 64'(pkt(7'd118, 32'h5A5A)));
    chk("both_no_ovf", 64'(credit_overflow), 64'd0);

    for (int i = 0; i < 37; i++)
      send(7'(119 + i), 32'h400 + 32'(i), "pre_ovf_pkt");
    vld_user2tx = 1'b0;
    din_bft2tx  = bft(3'd0, 2'b01);
    step();
    chk("hundred_credits", 64'(dut.credits), 64'd100);
    step();
    din_bft2tx = '0;
    chk("sat_credits", 64'(dut.credits), 64'd128);
    chk("sat_ovf", 64'(credit_overflow), 64'd1);

    din_bft2tx = bft(3'd1, 2'b01);
    step();
    din_bft2tx = bft(3'd0, 2'b00);
    step();
    din_bft2tx = {1'b0, 3'd0, 4'd0, 7'd0, 2'b01, 32'd0};
    step();
    din_bft2tx = '0;
    step();
    chk("ign_credits", 64'(dut.credits), 64'd128);
    chk("ovf_sticky", 64'(credit_overflow), 64'd1);

    for (int i = 28; i < 37; i++)
      send(7'(i), 32'h500 + 32'(i), "pre_rst_pkt");
    chk("pre_rst_addr", 64'(dut.wr_addr), 64'd37);

    din_user2tx = 32'hBEEF;
    reset = 1'b0;
    step();
    chk("mid_rst_dout", 64'(dout_tx2bft), 64'd0);
    chk("mid_rst_ack", 64'(ack_tx2user), 64'd0);
    reset = 1'b1;
    step();
    chk("rel_credits", 64'(dut.credits), 64'd128);
    chk("rel_ovf", 64'(credit_overflow), 64'd0);
    send(7'd0, 32'h600, "rel_first_pkt");
    vld_user2tx = 1'b0;
    step();
    chk("rel_idle", 64'(dout_tx2bft), 64'd0);
    chk("rel_credits_after", 64'(dut.credits), 64'd127);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
